if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the ID stage register and feeds it.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Registers {PC+4, instruction, valid} toward ID.
- Honours freeze from the hazard unit and redirects on a branch taken in EXE.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_hold_buf.sv | 40 ++++
 rtl/if_fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory req/ready bus between fetch stage and imem
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - single-entry {pc, instr} buffer for a fetch that lands during freeze
module if_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        full_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        full_q;

    // Clear beats load so a flush in the same cycle always leaves the buffer empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            full_q  <= 1'b0;
        end else if (clear_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            full_q  <= 1'b1;
        end else if (unload_i) begin
            full_q  <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign full_o  = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - IF stage: owns the PC, fetches over req/ready, feeds ID; IF_PERF_CNT_EN adds counters
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [31:0]         branch_addr,
    if_fetch_stage_if.master    imem,
    output logic [31:0]         pc_out,
    output logic [31:0]         instr_out,
    output logic                valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        req;
    logic        complete;
    logic [31:0] pc_inc;
    logic        buf_load, buf_unload, buf_clear, buf_full;
    logic [31:0] buf_pc, buf_instr;

    assign pc_inc   = pc_q + PC_INC;
    assign complete = req & imem.imem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            case (state_q)
                FETCH:   state_d = complete ? FETCH : DRAIN;
                DRAIN:   state_d = complete ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH:   if (complete && freeze) state_d = HOLD;
                HOLD:    if (!freeze)            state_d = FETCH;
                DRAIN:   if (complete)           state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Request is gated by rst so it drops the instant reset asserts.
    always_comb begin
        req            = rst && (state_q != HOLD);
        imem.imem_req  = req;
        imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        pc_out_d     = pc_out_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        buf_load     = 1'b0;
        buf_unload   = 1'b0;
        buf_clear    = 1'b0;
        if (branch_taken) begin
            pc_d      = branch_addr;
            pc_out_d  = '0;
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            buf_clear = 1'b1;
            if (state_q == FETCH && !complete) begin
                drain_addr_d = pc_q;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (complete) begin
                        pc_d = pc_inc;
                        if (freeze) begin
                            buf_load = 1'b1;
                        end else begin
                            pc_out_d = pc_inc;
                            instr_d  = imem.imem_rdata;
                            valid_d  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc_out_d   = buf_pc;
                        instr_d    = buf_instr;
                        valid_d    = buf_full;
                        buf_unload = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            pc_out_q     <= '0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pc_out_q     <= pc_out_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .clear_i  (buf_clear),
        .pc_i     (pc_inc),
        .instr_i  (imem.imem_rdata),
        .pc_o     (buf_pc),
        .instr_o  (buf_instr),
        .full_o   (buf_full)
    );

    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        delivered;

    assign delivered = !branch_taken && !freeze &&
                       ((state_q == FETCH && complete) || (state_q == HOLD && buf_full));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (delivered) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((req && !imem.imem_ready) || state_q == HOLD) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed vector bench for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] K   = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    if_fetch_stage_if imem_bus();

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_bus),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        rdy;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] pco;
        logic [31:0] ins;
        logic        vld;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    int n_cmp;
    int n_err;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ K;
    endfunction

    function automatic vec_t v(input logic fr, input logic br, input logic [31:0] ba,
                               input logic rdy, input logic req, input logic ca,
                               input logic [31:0] addr, input logic [31:0] pco,
                               input logic [31:0] ins, input logic vld);
        vec_t r;
        r.fr = fr; r.br = br; r.ba = ba; r.rdy = rdy;
        r.req = req; r.chk_addr = ca; r.addr = addr;
        r.pco = pco; r.ins = ins; r.vld = vld;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //        fr br ba            rdy req ca addr          pc_out        instr            vld
        vt[0]  = v(0, 0, 32'h0,       1,  1,  1, 32'h00,       32'h00,       NOP,             0);
        vt[1]  = v(0, 0, 32'h0,       1,  1,  1, 32'h04,       32'h04,       f(32'h00),       1);
        vt[2]  = v(0, 0, 32'h0,       1,  1,  1, 32'h08,       32'h08,       f(32'h04),       1);
        vt[3]  = v(0, 0, 32'h0,       1,  1,  1, 32'h0C,       32'h0C,       f(32'h08),       1);
        vt[4]  = v(0, 0, 32'h0,       0,  1,  1, 32'h10,       32'h10,       f(32'h0C),       1);
        vt[5]  = v(0, 0, 32'h0,       0,  1,  1, 32'h10,       32'h10,       f(32'h0C),       1);
        vt[6]  = v(0, 0, 32'h0,       0,  1,  1, 32'h10,       32'h10,       f(32'h0C),       1);
        vt[7]  = v(0, 0, 32'h0,       1,  1,  1, 32'h10,       32'h10,       f(32'h0C),       1);
        vt[8]  = v(0, 0, 32'h0,       1,  1,  1, 32'h14,       32'h14,       f(32'h10),       1);
        vt[9]  = v(0, 0, 32'h0,       1,  1,  1, 32'h18,       32'h18,       f(32'h14),       1);
        vt[10] = v(0, 0, 32'h0,       1,  1,  1, 32'h1C,       32'h1C,       f(32'h18),       1);
        vt[11] = v(1, 0, 32'h0,       1,  1,  1, 32'h20,       32'h20,       f(32'h1C),       1);
        vt[12] = v(1, 0, 32'h0,       1,  0,  0, 32'h00,       32'h20,       f(32'h1C),       1);
        vt[13] = v(0, 0, 32'h0,       1,  0,  0, 32'h00,       32'h20,       f(32'h1C),       1);
        vt[14] = v(0, 0, 32'h0,       1,  1,  1, 32'h24,       32'h24,       f(32'h20),       1);
        vt[15] = v(0, 0, 32'h0,       1,  1,  1, 32'h28,       32'h28,       f(32'h24),       1);
        vt[16] = v(0, 0, 32'h0,       1,  1,  1, 32'h2C,       32'h2C,       f(32'h28),       1);
        vt[17] = v(0, 1, 32'h100,     0,  1,  1, 32'h30,       32'h30,       f(32'h2C),       1);
        vt[18] = v(0, 0, 32'h0,       0,  1,  1, 32'h30,       32'h00,       NOP,             0);
        vt[19] = v(0, 0, 32'h0,       1,  1,  1, 32'h30,       32'h00,       NOP,             0);
        vt[20] = v(0, 0, 32'h0,       1,  1,  1, 32'h100,      32'h00,       NOP,             0);
        vt[21] = v(0, 0, 32'h0,       1,  1,  1, 32'h104,      32'h104,      f(32'h100),      1);
        vt[22] = v(1, 0, 32'h0,       1,  1,  1, 32'h108,      32'h108,      f(32'h104),      1);
        vt[23] = v(1, 1, 32'h200,     1,  0,  0, 32'h00,       32'h108,      f(32'h104),      1);
        vt[24] = v(0, 0, 32'h0,       1,  1,  1, 32'h200,      32'h00,       NOP,             0);
        vt[25] = v(0, 1, 32'hFFFFFFFC,1,  1,  1, 32'h204,      32'h204,      f(32'h200),      1);
        vt[26] = v(0, 0, 32'h0,       1,  1,  1, 32'hFFFFFFFC, 32'h00,       NOP,             0);
        vt[27] = v(0, 1, 32'h40,      0,  1,  1, 32'h00,       32'h00,       f(32'hFFFFFFFC), 1);
        vt[28] = v(0, 0, 32'h0,       0,  1,  1, 32'h00,       32'h00,       NOP,             0);

        rst                  = 1'b0;
        freeze               = 1'b0;
        branch_taken         = 1'b0;
        branch_addr          = '0;
        imem_bus.imem_ready  = 1'b0;
        imem_bus.imem_rdata  = '0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_req",    {31'd0, imem_bus.imem_req}, 32'd0);
        check("reset_pc_out", pc_out,                     32'd0);
        check("reset_instr",  instr_out,                  NOP);
        check("reset_valid",  {31'd0, valid_out},         32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst                 = 1'b1;
            freeze              = vt[i].fr;
            branch_taken        = vt[i].br;
            branch_addr         = vt[i].ba;
            imem_bus.imem_ready = vt[i].rdy;
            imem_bus.imem_rdata = f(vt[i].addr);
            #1;
            check($sformatf("v%0d_req", i), {31'd0, imem_bus.imem_req}, {31'd0, vt[i].req});
            if (vt[i].chk_addr) begin
                check($sformatf("v%0d_addr", i), imem_bus.imem_addr, vt[i].addr);
            end
            check($sformatf("v%0d_pc_out", i), pc_out,              vt[i].pco);
            check($sformatf("v%0d_instr", i),  instr_out,           vt[i].ins);
            check($sformatf("v%0d_valid", i),  {31'd0, valid_out},  {31'd0, vt[i].vld});
        end

        // Reset asserted mid-cycle while DRAIN holds an outstanding request.
        #2;
        rst = 1'b0;
        #1;
        check("drain_rst_req",    {31'd0, imem_bus.imem_req}, 32'd0);
        check("drain_rst_pc_out", pc_out,                     32'd0);
        check("drain_rst_instr",  instr_out,                  NOP);
        check("drain_rst_valid",  {31'd0, valid_out},         32'd0);

        @(negedge clk);
        rst                 = 1'b1;
        branch_taken        = 1'b0;
        freeze              = 1'b0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = f(32'h0);
        #1;
        check("rel_req",  {31'd0, imem_bus.imem_req}, 32'd1);
        check("rel_addr", imem_bus.imem_addr,         32'h0);
        check("rel_valid", {31'd0, valid_out},        32'd0);

        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        #1;
        check("rel_pc_out", pc_out,             32'h4);
        check("rel_instr",  instr_out,          f(32'h0));
        check("rel_valid2", {31'd0, valid_out}, 32'd1);
        check("rel_addr2",  imem_bus.imem_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
